// File: rtl/sbox_array.sv
// sbox_array: a bank of NBOX S-DES-style 4-in / OUT_W-out substitution boxes.
// The lookup tables live in registers and can be rewritten at runtime. Reset
// restores the standard S0 (even boxes) and S1 (odd boxes) contents. The
// result is registered behind a valid/ready handshake: one cycle of latency,
// one word per cycle of throughput, and it holds under backpressure.
//
// Optional build macro SBOX_PARITY_EN: each table entry stores an even-parity
// bit. The tbl_par_flip input inverts the stored parity on a write, for error
// injection. The out_err output flags any looked-up entry whose parity fails.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      input word valid
//   in_ready      input word accepted this cycle (!out_valid || out_ready)
//   in_data       4 bits per box; box i uses in_data[4*i+3:4*i]
//   out_valid     output register holds a result
//   out_ready     downstream accepts the result
//   out_data      OUT_W bits per box; box i at out_data[OUT_W*i +: OUT_W]
//   tbl_we        table write strobe
//   tbl_box       box index; an index >= NBOX makes the write a no-op
//   tbl_row       row of the entry to write
//   tbl_col       column of the entry to write
//   tbl_data      value written to the entry
//   tbl_par_flip  (SBOX_PARITY_EN) store inverted parity with this write
//   out_err       (SBOX_PARITY_EN) parity failure, registered with out_data
module sbox_array #(
  parameter int NBOX  = 2,
  parameter int OUT_W = 2,
  localparam int BOX_W = (NBOX > 1) ? $clog2(NBOX) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*NBOX-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W*NBOX-1:0] out_data,
  input  logic                  tbl_we,
  input  logic [BOX_W-1:0]      tbl_box,
  input  logic [1:0]            tbl_row,
  input  logic [1:0]            tbl_col,
`ifdef SBOX_PARITY_EN
  input  logic [OUT_W-1:0]      tbl_data,
  input  logic                  tbl_par_flip,
  output logic                  out_err
`else
  input  logic [OUT_W-1:0]      tbl_data
`endif
);

`ifdef SBOX_PARITY_EN
  localparam int ENT_W = OUT_W + 1;
`else
  localparam int ENT_W = OUT_W;
`endif

  // Default tables, flattened by index {row, col}. Entry k is at bits [2k+1:2k].
  localparam logic [31:0] S0_FLAT = {2'd2, 2'd3, 2'd1, 2'd3,  2'd3, 2'd1, 2'd2, 2'd0,
                                     2'd0, 2'd1, 2'd2, 2'd3,  2'd2, 2'd3, 2'd0, 2'd1};
  localparam logic [31:0] S1_FLAT = {2'd3, 2'd0, 2'd1, 2'd2,  2'd0, 2'd1, 2'd0, 2'd3,
                                     2'd3, 2'd1, 2'd0, 2'd2,  2'd3, 2'd2, 2'd1, 2'd0};

  function automatic logic [ENT_W-1:0] default_word(input int box, input int idx);
    logic [31:0]      flat;
    logic [OUT_W-1:0] d;
    flat = (box % 2 == 0) ? S0_FLAT : S1_FLAT;
    d = '0;
    d[1:0] = flat[2*idx +: 2];
`ifdef SBOX_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [ENT_W-1:0] tbl [NBOX][16];
  logic [ENT_W-1:0] wr_word;
  logic [3:0]       wr_idx;
  logic             wr_box_ok;

`ifdef SBOX_PARITY_EN
  // The stored bit makes the entry's parity even, unless the write injects an error.
  assign wr_word = {(^tbl_data) ^ tbl_par_flip, tbl_data};
`else
  assign wr_word = tbl_data;
`endif
  assign wr_idx    = {tbl_row, tbl_col};
  assign wr_box_ok = (32'(tbl_box) < NBOX);

  // Entries are indexed {row, col} with row = {b3,b0} and col = {b2,b1}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBOX; b++)
        for (int e = 0; e < 16; e++)
          tbl[b][e] <= default_word(b, e);
    end else if (tbl_we && wr_box_ok) begin
      for (int b = 0; b < NBOX; b++)
        for (int e = 0; e < 16; e++)
          if (tbl_box == BOX_W'(b) && wr_idx == 4'(e))
            tbl[b][e] <= wr_word;
    end
  end

  // Lookup reads the registered table, so a same-cycle write to the same
  // entry is seen only by the next lookup.
  logic [OUT_W*NBOX-1:0] lk_data;
  logic [3:0]            nib;
  logic [ENT_W-1:0]      ent;
`ifdef SBOX_PARITY_EN
  logic                  lk_err;
`endif

  always_comb begin
    lk_data = '0;
    nib     = '0;
    ent     = '0;
`ifdef SBOX_PARITY_EN
    lk_err  = 1'b0;
`endif
    for (int i = 0; i < NBOX; i++) begin
      nib = in_data[4*i +: 4];
      ent = tbl[i][{nib[3], nib[0], nib[2], nib[1]}];
      lk_data[OUT_W*i +: OUT_W] = ent[OUT_W-1:0];
`ifdef SBOX_PARITY_EN
      lk_err = lk_err | (^ent);
`endif
    end
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef SBOX_PARITY_EN
      out_err   <= 1'b0;
`endif
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= lk_data;
`ifdef SBOX_PARITY_EN
      out_err   <= lk_err;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sbox_array.sv
module tb_sbox_array;

  localparam int NBOX  = 2;
  localparam int OUT_W = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       tbl_we;
  logic [0:0] tbl_box;
  logic [1:0] tbl_row, tbl_col, tbl_data;
`ifdef SBOX_PARITY_EN
  logic       tbl_par_flip;
  logic       out_err;
`endif

  // A second instance with three boxes and 3-bit outputs, so that an
  // out-of-range box index can be expressed and zero-extension is visible.
  logic        in_valid3, in_ready3, out_valid3;
  logic [11:0] in_data3;
  logic [8:0]  out_data3;
  logic        tbl_we3;
  logic [1:0]  tbl_box3, tbl_row3, tbl_col3;
  logic [2:0]  tbl_data3;
`ifdef SBOX_PARITY_EN
  logic        tbl_par_flip3, out_err3;
`endif

  always #5 clk = ~clk;

  sbox_array #(.NBOX(NBOX), .OUT_W(OUT_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tbl_we(tbl_we), .tbl_box(tbl_box), .tbl_row(tbl_row), .tbl_col(tbl_col),
`ifdef SBOX_PARITY_EN
    .tbl_data(tbl_data), .tbl_par_flip(tbl_par_flip), .out_err(out_err)
`else
    .tbl_data(tbl_data)
`endif
  );

  sbox_array #(.NBOX(3), .OUT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(1'b1), .out_data(out_data3),
    .tbl_we(tbl_we3), .tbl_box(tbl_box3), .tbl_row(tbl_row3), .tbl_col(tbl_col3),
`ifdef SBOX_PARITY_EN
    .tbl_data(tbl_data3), .tbl_par_flip(tbl_par_flip3), .out_err(out_err3)
`else
    .tbl_data(tbl_data3)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the S-box tables as plain arrays, indexed [box][row][col].
  int s_def [2][4][4] = '{ '{'{1,0,3,2}, '{3,2,1,0}, '{0,2,1,3}, '{3,1,3,2}},
                           '{'{0,1,2,3}, '{2,0,1,3}, '{3,0,1,0}, '{2,1,0,3}} };
  int   m_tbl  [NBOX][4][4];
  bit   m_flip [NBOX][4][4];
  bit   mv;
  logic [4:0] exp_q [$];   // {err, data}

  task automatic model_reset();
    for (int b = 0; b < NBOX; b++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          m_tbl[b][r][c]  = s_def[b % 2][r][c];
          m_flip[b][r][c] = 1'b0;
        end
    mv = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [4:0] model_lookup(input logic [7:0] d);
    int v, nib, row, col, res;
    bit err;
    v = int'(d);
    res = 0;
    err = 1'b0;
    for (int b = 0; b < NBOX; b++) begin
      nib = (v >> (4*b)) & 15;
      row = ((nib >> 3) & 1) * 2 + (nib & 1);
      col = ((nib >> 2) & 1) * 2 + ((nib >> 1) & 1);
      res = res + (m_tbl[b][row][col] << (2*b));
      err = err | m_flip[b][row][col];
    end
    return {err, 4'(res)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+2: drive one cycle of inputs, check the handshake
  // against the model, update the model, and return at the next posedge+2.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                      input logic we, input int box, input int row, input int col,
                      input int data, input logic flip);
    bit xfer;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    tbl_we    = we;
    tbl_box   = 1'(box);
    tbl_row   = 2'(row);
    tbl_col   = 2'(col);
    tbl_data  = 2'(data);
`ifdef SBOX_PARITY_EN
    tbl_par_flip = flip;
`endif
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, !mv || ordy});
    check("out_valid", {31'd0, out_valid}, {31'd0, mv});
    xfer = iv && (!mv || ordy);
    if (xfer) exp_q.push_back(model_lookup(d));
    if (we && box < NBOX) begin
      m_tbl[box][row][col]  = data;
      m_flip[box][row][col] = flip;
    end
    if (xfer) mv = 1'b1;
    else if (ordy) mv = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic look(input logic [7:0] d);
    step(1'b1, d, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  // Monitor: each cycle a result is presented, compare it with the oldest
  // expected entry; retire that entry when downstream accepts it.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h expected=none at %0t", out_data, $time);
      end else begin
        check("sb_data", {28'd0, out_data}, {28'd0, exp_q[0][3:0]});
`ifdef SBOX_PARITY_EN
        check("sb_err", {31'd0, out_err}, {31'd0, exp_q[0][4]});
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] stream_in  [4] = '{8'h00, 8'hF0, 8'h11, 8'hFF};
  logic [3:0] stream_out [4] = '{4'h1, 4'hD, 4'hB, 4'hE};

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tbl_we = 1'b0; tbl_box = '0; tbl_row = '0; tbl_col = '0; tbl_data = '0;
    in_valid3 = 1'b0; in_data3 = '0;
    tbl_we3 = 1'b0; tbl_box3 = '0; tbl_row3 = '0; tbl_col3 = '0; tbl_data3 = '0;
`ifdef SBOX_PARITY_EN
    tbl_par_flip = 1'b0;
    tbl_par_flip3 = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #6 rst_n = 1'b1;
    @(posedge clk);
    #2;

    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {28'd0, out_data}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // First lookups after reset
    look(8'hF0);
    check("first_F0", {27'd0, out_valid, out_data}, {27'd0, 1'b1, 4'hD});
    look(8'h00);
    check("first_00", {28'd0, out_data}, 32'h1);

    // Back-to-back streaming
    for (int i = 0; i < 4; i++) begin
      look(stream_in[i]);
      check("stream_data", {28'd0, out_data}, {28'd0, stream_out[i]});
      check("stream_ready", {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result held for 5 cycles while F0 waits upstream
    look(8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hF0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
      check("bp_hold", {27'd0, out_valid, out_data}, {27'd0, 1'b1, 4'h1});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    look(8'hF0);
    check("bp_release", {28'd0, out_data}, 32'hD);

    // Write to box1 [0][0] concurrent with a lookup of that entry
    step(1'b1, 8'h00, 1'b1, 1'b1, 1, 0, 0, 2, 1'b0);
    check("wr_old_value", {28'd0, out_data}, 32'h1);
    look(8'h00);
    check("wr_new_value", {28'd0, out_data}, 32'h9);

    // Reset while a result is stalled, with a runtime-written table
    step(1'b0, 8'h00, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;
    look(8'h00);
    check("post_rst_default", {28'd0, out_data}, 32'h1);

`ifdef SBOX_PARITY_EN
    step(1'b0, 8'h00, 1'b1, 1'b1, 0, 3, 3, 2, 1'b1);
    look(8'h0F);
    check("par_err_set", {31'd0, out_err}, 32'd1);
    look(8'h00);
    check("par_err_clear", {31'd0, out_err}, 32'd0);
`endif

    // Randomized traffic with concurrent table writes
    for (int i = 0; i < 400; i++) begin
      logic flip;
      flip = 1'b0;
`ifdef SBOX_PARITY_EN
      flip = ($urandom_range(0, 7) == 0);
`endif
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0, int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), flip);
    end

    // Drain (bounded)
    for (int i = 0; i < 4; i++)
      step(1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    check("drain_empty", exp_q.size(), 32'd0);

    // Three-box instance: out-of-range write ignored, in-range write applied
    tbl_we3 = 1'b1; tbl_box3 = 2'd3; tbl_row3 = 2'd0; tbl_col3 = 2'd0; tbl_data3 = 3'b111;
    @(posedge clk); #2;
    tbl_we3 = 1'b0; in_valid3 = 1'b1; in_data3 = 12'h000;
    @(posedge clk); #2;
    in_valid3 = 1'b0;
    check("oor_ignored", {22'd0, out_valid3, out_data3}, {22'd0, 1'b1, 9'h041});
    tbl_we3 = 1'b1; tbl_box3 = 2'd2; tbl_data3 = 3'b110;
    @(posedge clk); #2;
    tbl_we3 = 1'b0; in_valid3 = 1'b1;
    @(posedge clk); #2;
    in_valid3 = 1'b0;
    check("box2_write", {23'd0, out_data3}, {23'd0, 9'h181});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbox_array.md
Name: sbox_array

Overview:
- Parametrised bank of NBOX S-DES-style substitution boxes. Each box takes a 4-bit input and produces an OUT_W-bit output.
- Sits in the round datapath after expansion/key-XOR and before the P4 permutation.
- Successor to the fixed combinational S-box:
  - lookup tables are held in registers and can be rewritten at runtime;
  - reset restores the standard S0/S1 contents;
  - the result is registered behind a valid/ready handshake (1-cycle latency with backpressure).

Parameters:
- NBOX, 2, number of parallel S-boxes (≥1).
- OUT_W, 2, output bits per box (≥2). Default table entries are zero-extended to OUT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word this cycle.
- in_data  in  4*NBOX  box i input = in_data[4*i+3:4*i].
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W*NBOX  box i result = out_data[OUT_W*i+OUT_W-1:OUT_W*i].
- tbl_we  in  1  table write strobe.
- tbl_box  in  clog2(NBOX) min 1  box index for the write.
- tbl_row  in  2  row index for the write.
- tbl_col  in  2  column index for the write.
- tbl_data  in  OUT_W  entry value to write.

Behaviour:
- Addressing per box, with input bits b[3:0]:
  - row = {b3, b0};
  - col = {b2, b1}.
- Reset (rst_n low, asynchronous):
  - out_valid=0 and out_data=0.
  - Tables load their defaults:
    - even-index boxes = S0 rows {1,0,3,2}{3,2,1,0}{0,2,1,3}{3,1,3,2};
    - odd-index boxes = S1 rows {0,1,2,3}{2,0,1,3}{3,0,1,0}{2,1,0,3}.
  - in_ready follows its combinational equation.
- Reset release: synchronous deassertion is handled upstream. Behaviour is defined from the first clk edge after rst_n goes high.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer occurs on a clk edge where in_valid && in_ready.
  - On transfer, out_data is loaded with all NBOX lookups of in_data and out_valid is set to 1. Latency is 1 cycle.
  - out_valid && out_ready with no new transfer: out_valid clears to 0; out_data holds its last value.
  - out_valid && out_ready && in_valid in the same cycle: a new result is loaded and out_valid stays 1. Full throughput, 1 word/cycle.
  - out_valid && !out_ready: out_data and out_valid hold, in_ready=0. Upstream must hold in_data.
- Table write:
  - tbl_we on a clk edge writes tbl_data to entry [tbl_box][tbl_row][tbl_col].
  - tbl_box ≥ NBOX: the write is ignored.
  - Write and lookup in the same cycle to the same entry: the lookup uses the OLD value. The new value is visible from the next cycle.
  - Writes are legal at any time, independent of the handshake. They do not stall and do not affect out_valid.
- Reset mid-operation:
  - any pending out_valid result is discarded;
  - runtime-written table contents are lost and revert to the defaults.
- No internal states beyond the out_valid flag and the table registers. There is no FSM, so no illegal states exist.

Optional Feature:
- Macro: SBOX_PARITY_EN.
- When defined:
  - Each table entry stores an even-parity bit, computed on reset defaults and on every write.
  - Adds input port tbl_par_flip (1). When high together with tbl_we, the stored parity bit is inverted (error injection).
  - Adds output port out_err (1). It is registered with out_data, set if any box's looked-up entry fails parity, and obeys the same load/hold rules as out_data.
  - out_err resets to 0.
- When undefined:
  - no parity storage;
  - neither tbl_par_flip nor out_err ports exist;
  - table width is exactly OUT_W.

Test Plan:
- Reset then lookup (NBOX=2, OUT_W=2):
  - in_data=8'hF0, in_valid=1, out_ready=1 → the next cycle shows out_valid=1, out_data=4'hD (box0=01, box1=11).
  - in_data=8'h00 → out_data=4'h1.
- Streaming: four back-to-back words 8'h00, 8'hF0, 8'h11, 8'hFF with out_ready=1.
  - in_ready stays 1.
  - Outputs 4'h1, 4'hD, 4'hB, 4'hE appear on consecutive cycles.
- Backpressure: out_ready=0 after the first transfer of 8'h00.
  - in_ready=0; out_data holds 4'h1 for 5 cycles.
  - Raising out_ready with 8'hF0 pending → 4'hD on the next cycle, with no loss or duplication.
- Table write:
  - tbl_we, box=1, row=0, col=0, data=2'b10, while simultaneously looking up 8'h00 → that result is 4'h1 (old value).
  - Next lookup of 8'h00 → 4'h9.
  - tbl_box=3 (out of range) → no table change.
- Reset mid-op:
  - rewrite box0 [0][0]=2'b00, hold out_valid=1 with out_ready=0, pulse rst_n low → out_valid=0 immediately.
  - After release, lookup of 8'h00 → 4'h1 (defaults restored).
- With SBOX_PARITY_EN: write box0 [3][3] with tbl_par_flip=1, then look up 8'h0F → out_err=1. Looking up 8'h00 → out_err=0.
